// File: rtl/fp_div_iter.sv
// rtl/fp_div_iter.sv - iterative restoring floating-point divider, result = a_operand / b_operand
//
// Packed format {sign, exponent[EXP_W], mantissa[MAN_W]}. The hidden bit is 1
// when the exponent field is nonzero. One quotient bit is produced per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operands valid
//   in_ready     divider idle, operands can be accepted
//   a_operand    dividend
//   b_operand    divisor
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts result
//   result       quotient
//   div_by_zero  set with the current result when the divisor was zero
//
// Optional build macro FP_DIV_POW2_BYPASS_EN: a non-special divisor with a zero
// fraction (a power of two) skips the DIVIDE state and loads the quotient directly.

`ifndef EXPONENT
`define EXPONENT 8
`endif
`ifndef MANTISSA
`define MANTISSA 23
`endif

module fp_div_iter #(
  parameter int EXP_W = `EXPONENT,
  parameter int MAN_W = `MANTISSA,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_operand,
  input  logic [EXP_W+MAN_W:0]   b_operand,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   div_by_zero
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int Q_W   = MAN_W + 3;
  localparam int R_W   = MAN_W + 2;
  localparam int CNT_W = $clog2(Q_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_NORM   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic signed [EXP_W+1:0] E_ZERO = '0;
  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((2**EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] E_BIAS = (EXP_W+2)'(BIAS);

  logic [1:0]       state;
  logic             sign_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  logic [MAN_W:0]   sb_r;
  logic [R_W-1:0]   rem_r;
  logic [Q_W-1:0]   q_r;
  logic [CNT_W-1:0] cnt_r;

  // Operand decode at accept
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MAN_W:0]   a_sig, b_sig;
  logic             in_sign, any_special, a_zero, b_zero;

  assign a_exp       = a_operand[W-2:MAN_W];
  assign b_exp       = b_operand[W-2:MAN_W];
  assign a_frac      = a_operand[MAN_W-1:0];
  assign b_frac      = b_operand[MAN_W-1:0];
  assign a_sig       = {|a_exp, a_frac};
  assign b_sig       = {|b_exp, b_frac};
  assign in_sign     = a_operand[W-1] ^ b_operand[W-1];
  assign any_special = (&a_exp) | (&b_exp);
  assign a_zero      = (a_exp == '0) && (a_frac == '0);
  assign b_zero      = (b_exp == '0) && (b_frac == '0);

  // One restoring step: the remainder after subtraction is below the divisor,
  // so shifting left by one always fits in R_W bits.
  logic           ge;
  logic [R_W-1:0] rem_sub, rem_next;

  assign ge       = rem_r >= {1'b0, sb_r};
  assign rem_sub  = ge ? (rem_r - {1'b0, sb_r}) : rem_r;
  assign rem_next = rem_sub << 1;

  // Normalise, round (nearest, ties away) and range-check the exponent
  logic                    q_top, guard, round_ovf;
  logic [MAN_W-1:0]        mant, mant_r;
  logic [MAN_W:0]          mant_sum;
  logic signed [EXP_W+1:0] e_calc;
  logic [W-1:0]            norm_result;

  always_comb begin
    q_top     = q_r[Q_W-1];
    mant      = q_top ? q_r[MAN_W+1:2] : q_r[MAN_W:1];
    guard     = q_top ? q_r[1] : q_r[0];
    mant_sum  = {1'b0, mant} + (MAN_W+1)'(guard);
    round_ovf = mant_sum[MAN_W];
    mant_r    = round_ovf ? '0 : mant_sum[MAN_W-1:0];
    e_calc    = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + E_BIAS
              - $signed((EXP_W+2)'(!q_top)) + $signed((EXP_W+2)'(round_ovf));
    if (e_calc <= E_ZERO)
      norm_result = {sign_r, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else if (e_calc >= E_MAX)
      norm_result = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      norm_result = {sign_r, e_calc[EXP_W-1:0], mant_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sign_r      <= 1'b0;
      ea_r        <= '0;
      eb_r        <= '0;
      sb_r        <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      cnt_r       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            ea_r   <= a_exp;
            eb_r   <= b_exp;
            sb_r   <= b_sig;
            rem_r  <= {1'b0, a_sig};
            q_r    <= '0;
            cnt_r  <= '0;
            if (any_special) begin
              result      <= {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              div_by_zero <= 1'b0;
              state       <= S_DONE;
            end else if (b_zero) begin
              result      <= {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else if (a_zero) begin
              result      <= {in_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
              div_by_zero <= 1'b0;
              state       <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
`ifdef FP_DIV_POW2_BYPASS_EN
              // Divisor significand is exactly 1.0: quotient is the dividend
              // significand scaled to the quotient width.
              if (b_frac == '0) begin
                q_r   <= {a_sig, 2'b00};
                state <= S_NORM;
              end else begin
                state <= S_DIVIDE;
              end
`else
              state <= S_DIVIDE;
`endif
            end
          end
        end
        S_DIVIDE: begin
          rem_r <= rem_next;
          q_r   <= {q_r[Q_W-2:0], ge};
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_W'(Q_W - 1))
            state <= S_NORM;
        end
        S_NORM: begin
          result <= norm_result;
          state  <= S_DONE;
        end
        default: begin
          if (out_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule
